// File: rtl/half_add_sub_unit.sv
// Registered bank of independent 1-bit half adders and half subtractors, one valid for both paths.
// Optional registered parity output when HALF_ADD_SUB_PARITY_EN is defined.
module half_add_sub_unit #(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] a1,
  input  logic [LANES-1:0] b1,
  output logic             out_valid,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] carry,
  output logic [LANES-1:0] diff,
  output logic [LANES-1:0] borrow
`ifdef HALF_ADD_SUB_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [LANES-1:0] w_sum;
  logic [LANES-1:0] w_carry;
  logic [LANES-1:0] w_diff;
  logic [LANES-1:0] w_borrow;

  logic             r_valid;
  logic [LANES-1:0] r_sum;
  logic [LANES-1:0] r_carry;
  logic [LANES-1:0] r_diff;
  logic [LANES-1:0] r_borrow;

  // Pure bitwise ops: no cross-lane propagation by construction.
  always_comb begin
    w_sum    = a ^ b;
    w_carry  = a & b;
    w_diff   = a1 ^ b1;
    w_borrow = ~a1 & b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_sum    <= '0;
      r_carry  <= '0;
      r_diff   <= '0;
      r_borrow <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum    <= w_sum;
        r_carry  <= w_carry;
        r_diff   <= w_diff;
        r_borrow <= w_borrow;
      end
    end
  end

`ifdef HALF_ADD_SUB_PARITY_EN
  logic r_parity;

  // Parity is taken from the combinational results so it matches the values being registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (in_valid) begin
      r_parity <= ^{w_sum, w_carry, w_diff, w_borrow};
    end
  end

  assign parity = r_parity;
`endif

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign diff      = r_diff;
  assign borrow    = r_borrow;

endmodule

// File: tb/tb_half_add_sub_unit.sv
// Table-driven bench: a 4-lane and a 1-lane instance share stimulus (lane 0 feeds the 1-lane unit).
// Parity checks are compiled in when HALF_ADD_SUB_PARITY_EN is defined.
module tb_half_add_sub_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b, a1, b1;

  logic       ov4, ov1;
  logic [3:0] sum4, carry4, diff4, borrow4;
  logic [0:0] sum1, carry1, diff1, borrow1;
`ifdef HALF_ADD_SUB_PARITY_EN
  logic       par4, par1;
`endif

  int total = 0;
  int bad   = 0;

  half_add_sub_unit #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .a1(a1), .b1(b1),
    .out_valid(ov4), .sum(sum4), .carry(carry4), .diff(diff4), .borrow(borrow4)
`ifdef HALF_ADD_SUB_PARITY_EN
    , .parity(par4)
`endif
  );

  half_add_sub_unit #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a[0]), .b(b[0]), .a1(a1[0]), .b1(b1[0]),
    .out_valid(ov1), .sum(sum1), .carry(carry1), .diff(diff1), .borrow(borrow1)
`ifdef HALF_ADD_SUB_PARITY_EN
    , .parity(par1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] a, b, a1, b1;
    logic       e_vld;
    logic [3:0] e_sum, e_carry, e_diff, e_borrow;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_vld,
                           input logic [3:0] es, input logic [3:0] ec,
                           input logic [3:0] ed, input logic [3:0] eb);
    chk({tag, " valid4"},  {3'b0, ov4}, {3'b0, e_vld});
    chk({tag, " sum4"},    sum4,    es);
    chk({tag, " carry4"},  carry4,  ec);
    chk({tag, " diff4"},   diff4,   ed);
    chk({tag, " borrow4"}, borrow4, eb);
    chk({tag, " valid1"},  {3'b0, ov1},     {3'b0, e_vld});
    chk({tag, " sum1"},    {3'b0, sum1},    {3'b0, es[0]});
    chk({tag, " carry1"},  {3'b0, carry1},  {3'b0, ec[0]});
    chk({tag, " diff1"},   {3'b0, diff1},   {3'b0, ed[0]});
    chk({tag, " borrow1"}, {3'b0, borrow1}, {3'b0, eb[0]});
`ifdef HALF_ADD_SUB_PARITY_EN
    chk({tag, " parity4"}, {3'b0, par4}, {3'b0, ^{es, ec, ed, eb}});
    chk({tag, " parity1"}, {3'b0, par1}, {3'b0, ^{es[0], ec[0], ed[0], eb[0]}});
`endif
  endtask

  task automatic apply(input logic r, input logic v, input logic [3:0] ia,
                       input logic [3:0] ib, input logic [3:0] ia1, input logic [3:0] ib1);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = ia;
    b        = ib;
    a1       = ia1;
    b1       = ib1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst  vld  a      b      a1     b1     e_vld sum    carry  diff   borrow
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h5, 4'hA, 4'h3, 4'h6, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 4'hF, 4'h0, 4'hF, 4'hF};
    tbl[4]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'hC, 4'hA, 4'hC, 4'hA, 1'b1, 4'h6, 4'h8, 4'h6, 4'h2};
    tbl[7]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 1'b1, 4'h5, 4'h3, 4'h3, 4'h5, 1'b1, 4'h6, 4'h1, 4'h6, 4'h4};
    tbl[10] = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{1'b0, 1'b1, 4'h3, 4'h1, 4'h2, 4'h7, 1'b1, 4'h2, 4'h1, 4'h5, 4'h5};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[13] = '{1'b0, 1'b0, 4'hx, 4'hx, 4'hx, 4'hx, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; a1 = '0; b1 = '0;

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].rst, tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].a1, tbl[i].b1);
      check_all($sformatf("vec%0d", i), tbl[i].e_vld,
                tbl[i].e_sum, tbl[i].e_carry, tbl[i].e_diff, tbl[i].e_borrow);
    end

    // One valid beat then several idle cycles with changing inputs: result must stay held.
    apply(1'b0, 1'b1, 4'h9, 4'hA, 4'h6, 4'hB);
    check_all("seq_load", 1'b1, 4'h3, 4'h8, 4'hD, 4'h9);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 4'(k), 4'hF, 4'h0, 4'(k + 7));
      check_all($sformatf("seq_hold%0d", k), 1'b0, 4'h3, 4'h8, 4'hD, 4'h9);
    end

    // Reset while idle clears held data; the next valid edge produces a result immediately.
    apply(1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF);
    check_all("seq_rst", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    apply(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h1);
    check_all("seq_after_rst", 1'b1, 4'h0, 4'h1, 4'h1, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
